// File: rtl/reg_fifo.sv
// Register-based synchronous FIFO with handshakes, occupancy count and one-cycle
// overflow/underflow pulses. Explicit pointer wrap supports non-power-of-two DEPTH.
module reg_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             wr_acc;
  logic             rd_acc;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign dout      = dout_q;
  assign dout_valid = dout_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Acceptance uses flags as seen before the edge, so a full FIFO never passes through.
  always_comb begin
    wr_acc = wr_en && !full;
    rd_acc = rd_en && !empty;

    wp_d = wp_q;
    if (wr_acc) begin
      wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
    end

    rp_d = rp_q;
    if (rd_acc) begin
      rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
    end

    cnt_d = cnt_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_acc) begin
      mem_q[wp_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= rd_acc;
      overflow_q   <= wr_en && full;
      underflow_q  <= rd_en && empty;
      if (rd_acc) begin
        dout_q <= mem_q[rp_q];
      end
    end
  end

endmodule

// File: tb/tb_reg_fifo.sv
// Directed bench for reg_fifo: one DEPTH=4 and one DEPTH=3 instance share clock and reset.
module tb_reg_fifo;

  logic       clk;
  logic       reset;

  logic       wr4, rd4;
  logic [7:0] din4, dout4;
  logic       dv4, full4, empty4, ov4, uf4;
  logic [2:0] cnt4;

  logic       wr3, rd3;
  logic [7:0] din3, dout3;
  logic       dv3, full3, empty3, ov3, uf3;
  logic [1:0] cnt3;

  int compared;
  int mismatched;

  reg_fifo #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr4),
    .din        (din4),
    .rd_en      (rd4),
    .dout       (dout4),
    .dout_valid (dv4),
    .full       (full4),
    .empty      (empty4),
    .count      (cnt4),
    .overflow   (ov4),
    .underflow  (uf4)
  );

  reg_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr3),
    .din        (din3),
    .rd_en      (rd3),
    .dout       (dout3),
    .dout_valid (dv3),
    .full       (full3),
    .empty      (empty3),
    .count      (cnt3),
    .overflow   (ov3),
    .underflow  (uf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic cyc(input bit sel3, input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wr4 = sel3 ? 1'b0 : w;
    rd4 = sel3 ? 1'b0 : r;
    din4 = d;
    wr3 = sel3 ? w : 1'b0;
    rd3 = sel3 ? r : 1'b0;
    din3 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [7:0] d, input logic v, input logic [2:0] c,
                      input logic o, input logic u);
    check({tag, ".dout"}, 32'(dout4), 32'(d));
    check({tag, ".valid"}, 32'(dv4), 32'(v));
    check({tag, ".count"}, 32'(cnt4), 32'(c));
    check({tag, ".full"}, 32'(full4), 32'(c == 3'd4));
    check({tag, ".empty"}, 32'(empty4), 32'(c == 3'd0));
    check({tag, ".ovf"}, 32'(ov4), 32'(o));
    check({tag, ".udf"}, 32'(uf4), 32'(u));
  endtask

  task automatic chk3(input string tag, input logic [7:0] d, input logic v, input logic [1:0] c,
                      input logic o, input logic u);
    check({tag, ".dout"}, 32'(dout3), 32'(d));
    check({tag, ".valid"}, 32'(dv3), 32'(v));
    check({tag, ".count"}, 32'(cnt3), 32'(c));
    check({tag, ".full"}, 32'(full3), 32'(c == 2'd3));
    check({tag, ".empty"}, 32'(empty3), 32'(c == 2'd0));
    check({tag, ".ovf"}, 32'(ov3), 32'(o));
    check({tag, ".udf"}, 32'(uf3), 32'(u));
  endtask

  initial begin
    logic [7:0] fill_v [4];
    compared   = 0;
    mismatched = 0;
    fill_v[0] = 8'hA1; fill_v[1] = 8'hB2; fill_v[2] = 8'hC3; fill_v[3] = 8'hD4;
    reset = 1'b0;
    wr4 = 1'b0; rd4 = 1'b0; din4 = '0;
    wr3 = 1'b0; rd3 = 1'b0; din3 = '0;
    #12;
    chk4("rst4", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    chk3("rst3", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Fill DEPTH=4, then overflow on a 5th write.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, fill_v[i]);
      chk4("fill", 8'h00, 1'b0, 3'(i + 1), 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'hE5);
    chk4("ovf", 8'h00, 1'b0, 3'd4, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk4("ovf_clr", 8'h00, 1'b0, 3'd4, 1'b0, 1'b0);

    // Drain in order, then underflow.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk4("drain", fill_v[i], 1'b1, 3'(3 - i), 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk4("udf", 8'hD4, 1'b0, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk4("udf_clr", 8'hD4, 1'b0, 3'd0, 1'b0, 1'b0);

    // Simultaneous read/write while full: read wins, 0x55 is dropped.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(8'h11 * (i + 1)));
    end
    cyc(1'b0, 1'b1, 1'b1, 8'h55);
    chk4("full_rw", 8'h11, 1'b1, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk4("full_rw_drain", 8'(8'h11 * (i + 2)), 1'b1, 3'(2 - i), 1'b0, 1'b0);
    end

    // Simultaneous read/write while empty: write wins.
    cyc(1'b0, 1'b1, 1'b1, 8'h66);
    chk4("empty_rw", 8'h44, 1'b0, 3'd1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk4("empty_rw_rd", 8'h66, 1'b1, 3'd0, 1'b0, 1'b0);

    // Streaming at count 2 across several pointer wraps.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h01);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'(i + 2));
      chk4("wrap", 8'(i), 1'b1, 3'd2, 1'b0, 1'b0);
    end
    for (int i = 8; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk4("wrap_tail", 8'(i), 1'b1, 3'(9 - i), 1'b0, 1'b0);
    end

    // Asynchronous reset mid-run with count 3 and a pending dout_valid.
    cyc(1'b0, 1'b1, 1'b0, 8'h21);
    cyc(1'b0, 1'b1, 1'b0, 8'h22);
    cyc(1'b0, 1'b1, 1'b0, 8'h23);
    cyc(1'b0, 1'b1, 1'b1, 8'h24);
    chk4("pre_rst", 8'h21, 1'b1, 3'd3, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk4("mid_rst", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // DEPTH=3: fill, overflow, drain, underflow.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, fill_v[i]);
      chk3("d3_fill", 8'h00, 1'b0, 2'(i + 1), 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b0, 8'hE5);
    chk3("d3_ovf", 8'h00, 1'b0, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      chk3("d3_drain", fill_v[i], 1'b1, 2'(2 - i), 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk3("d3_udf", 8'hC3, 1'b0, 2'd0, 1'b0, 1'b1);

    // DEPTH=3 streaming across the 2 -> 0 wrap.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h01);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 8'(i + 2));
      chk3("d3_wrap", 8'(i), 1'b1, 2'd2, 1'b0, 1'b0);
    end
    for (int i = 8; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      chk3("d3_wrap_tail", 8'(i), 1'b1, 2'(9 - i), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
